// File: rtl/dbg_loader_pkg.sv
// Shared command/response codes and FSM state type for the UART debug loader.
package dbg_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_HALT  = 8'h48;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  localparam logic [2:0] LEN_SHORT = 3'd1;
  localparam logic [2:0] LEN_WORD  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_MEM,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dbg_resp_tx.sv
// Response shifter: sends 1 or 4 bytes LSB first over a valid/ready handshake.
module dbg_resp_tx (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_len,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        done
);

  logic [31:0] shift_reg;
  logic [2:0]  count_reg;
  logic [7:0]  data_reg;
  logic        valid_reg;
  logic        fire;

  assign fire     = valid_reg && tx_ready;
  assign done     = fire && (count_reg == 3'd1);
  assign tx_data  = data_reg;
  assign tx_valid = valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      count_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= load_data;
      count_reg <= load_len;
      data_reg  <= load_data[7:0];
      valid_reg <= 1'b1;
    end else if (fire) begin
      // The following byte is already on tx_data the cycle after the handshake.
      if (count_reg == 3'd1) begin
        valid_reg <= 1'b0;
        count_reg <= '0;
      end else begin
        shift_reg <= {8'h00, shift_reg[31:8]};
        data_reg  <= shift_reg[15:8];
        count_reg <= count_reg - 3'd1;
      end
    end
  end

endmodule

// File: rtl/dbg_loader.sv
// UART packet debug loader: word read/write into memory and CPU run/halt control.
module dbg_loader
  import dbg_loader_pkg::*;
#(
  parameter int MEM_CYC     = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dbg_mem_op,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  output logic [3:0]  dbg_wren,
  input  logic [31:0] dbg_di,
  output logic        cpu_n_reset
);

  localparam int MW = $clog2(MEM_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t        state_reg, state_next;
  logic [7:0]    cmd_reg, cmd_next;
  logic [1:0]    byte_cnt_reg, byte_cnt_next;
  logic [31:0]   adr_reg, adr_next;
  logic [31:0]   do_reg, do_next;
  logic [MW-1:0] mem_cnt_reg, mem_cnt_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          cpu_reg, cpu_next;

  logic          load;
  logic [31:0]   load_data;
  logic [2:0]    load_len;
  logic          resp_done;
  logic [31:0]   addr_full;
  logic [31:0]   data_full;

  // Little-endian assembly: each new byte enters at the top and walks down.
  assign addr_full = {rx_data, adr_reg[31:8]};
  assign data_full = {rx_data, do_reg[31:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= '0;
      byte_cnt_reg <= '0;
      adr_reg      <= '0;
      do_reg       <= '0;
      mem_cnt_reg  <= '0;
      to_cnt_reg   <= '0;
      cpu_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      byte_cnt_reg <= byte_cnt_next;
      adr_reg      <= adr_next;
      do_reg       <= do_next;
      mem_cnt_reg  <= mem_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      cpu_reg      <= cpu_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    byte_cnt_next = byte_cnt_reg;
    adr_next      = adr_reg;
    do_next       = do_reg;
    mem_cnt_next  = '0;
    to_cnt_next   = '0;
    cpu_next      = cpu_reg;
    load          = 1'b0;
    load_data     = {24'h0, RSP_ACK};
    load_len      = LEN_SHORT;

    case (state_reg)
      ST_IDLE: begin
        byte_cnt_next = '0;
        if (rx_valid) begin
          case (rx_data)
            CMD_WRITE, CMD_READ: begin
              cmd_next   = rx_data;
              state_next = ST_ADDR;
            end
            CMD_GO: begin
              cpu_next   = 1'b1;
              load       = 1'b1;
              state_next = ST_RESP;
            end
            CMD_HALT: begin
              cpu_next   = 1'b0;
              load       = 1'b1;
              state_next = ST_RESP;
            end
            default: begin
              load       = 1'b1;
              load_data  = {24'h0, RSP_NAK};
              state_next = ST_RESP;
            end
          endcase
        end
      end

      ST_ADDR: begin
        if (rx_valid) begin
          adr_next      = addr_full;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            if (cmd_reg == CMD_WRITE) begin
              state_next = ST_DATA;
            end else if (addr_full[1:0] != 2'b00 || cpu_reg) begin
              load       = 1'b1;
              load_data  = {24'h0, RSP_NAK};
              state_next = ST_RESP;
            end else begin
              state_next = ST_MEM;
            end
          end
        end else if (to_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
          state_next = ST_IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      ST_DATA: begin
        if (rx_valid) begin
          do_next       = data_full;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            if (adr_reg[1:0] != 2'b00 || cpu_reg) begin
              load       = 1'b1;
              load_data  = {24'h0, RSP_NAK};
              state_next = ST_RESP;
            end else begin
              state_next = ST_MEM;
            end
          end
        end else if (to_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
          state_next = ST_IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      ST_MEM: begin
        mem_cnt_next = mem_cnt_reg + 1'b1;
        if (mem_cnt_reg == MW'(MEM_CYC - 1)) begin
          // Read data is taken straight into the shifter on the final bus cycle.
          mem_cnt_next = '0;
          load         = 1'b1;
          state_next   = ST_RESP;
          if (cmd_reg == CMD_READ) begin
            load_data = dbg_di;
            load_len  = LEN_WORD;
          end
        end
      end

      ST_RESP: begin
        if (resp_done) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign dbg_mem_op  = (state_reg == ST_MEM);
  assign dbg_wren    = (state_reg == ST_MEM && cmd_reg == CMD_WRITE) ? 4'hF : 4'h0;
  assign dbg_adr     = {adr_reg[31:2], 2'b00};
  assign dbg_do      = do_reg;
  assign cpu_n_reset = cpu_reg;

  dbg_resp_tx u_resp_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .load_len  (load_len),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .done      (resp_done)
  );

endmodule

// File: tb/tb_dbg_loader.sv
// Scoreboard bench for dbg_loader: expected tx bytes and memory windows are queued, monitors compare.
module tb_dbg_loader;

  localparam int MEM_CYC = 4;
  localparam int TO_CYC  = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        dbg_mem_op;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_di = 32'hFFFF_FFFF;
  logic        cpu_n_reset;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dout;
    logic [3:0]  wren;
    bit          chk_do;
    int          len;
  } mem_t;

  logic [7:0]  tx_q[$];
  mem_t        mem_q[$];
  logic [31:0] rd_word = 32'h0001_0537;

  dbg_loader #(.MEM_CYC(MEM_CYC), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dbg_mem_op(dbg_mem_op), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
    .dbg_wren(dbg_wren), .dbg_di(dbg_di), .cpu_n_reset(cpu_n_reset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // tx monitor: pops on each handshake, checks data holds while stalled
  logic       stalled = 1'b0;
  logic [7:0] stall_data = '0;
  always @(negedge clk) begin
    if (tx_valid) begin
      if (stalled && tx_data !== stall_data) chk("tx_hold", {24'h0, tx_data}, {24'h0, stall_data});
      if (tx_ready) begin
        if (tx_q.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hxxxx_xx00);
        else begin
          automatic logic [7:0] e = tx_q.pop_front();
          chk("tx_byte", {24'h0, tx_data}, {24'h0, e});
          $display("tx byte %h (expected %h)", tx_data, e);
        end
        stalled = 1'b0;
      end else begin
        stalled    = 1'b1;
        stall_data = tx_data;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // memory monitor: checks each dbg_mem_op window and drives read data on its last cycle
  bit          in_win = 0;
  int          win_len = 0;
  mem_t        cur;
  logic [31:0] first_adr, first_do;
  logic [3:0]  first_wren;
  always @(negedge clk) begin
    if (dbg_mem_op) begin
      if (!in_win) begin
        in_win = 1; win_len = 1;
        first_adr = dbg_adr; first_do = dbg_do; first_wren = dbg_wren;
        if (mem_q.size() == 0) begin
          chk("mem_unexpected", {31'h0, dbg_mem_op}, 32'h0);
          cur = '{adr: 32'h0, dout: 32'h0, wren: 4'h0, chk_do: 0, len: -1};
        end else begin
          cur = mem_q.pop_front();
          chk("mem_adr", dbg_adr, cur.adr);
          chk("mem_wren", {28'h0, dbg_wren}, {28'h0, cur.wren});
          if (cur.chk_do) chk("mem_do", dbg_do, cur.dout);
          $display("mem window adr %h do %h wren %h", dbg_adr, dbg_do, dbg_wren);
        end
      end else begin
        win_len++;
        if (dbg_adr !== first_adr || dbg_do !== first_do || dbg_wren !== first_wren)
          chk("mem_stable", dbg_adr ^ first_adr ^ dbg_do ^ first_do, 32'h0);
      end
      dbg_di = (win_len == MEM_CYC) ? rd_word : 32'hFFFF_FFFF;
    end else begin
      if (dbg_wren !== 4'h0) chk("wren_idle", {28'h0, dbg_wren}, 32'h0);
      if (in_win) begin
        in_win = 0;
        if (cur.len >= 0) chk("mem_len", win_len, cur.len);
      end
      dbg_di = 32'hFFFF_FFFF;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    cycles(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic exp_mem(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                         input bit cd, input int len);
    mem_t m;
    m.adr = a; m.dout = d; m.wren = w; m.chk_do = cd; m.len = len;
    mem_q.push_back(m);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || mem_q.size() != 0 || tx_valid || in_win) && n < 3000) begin
      cycles(1);
      n++;
    end
    if (n >= 3000) chk({name, "_timeout"}, tx_q.size() + mem_q.size(), 32'h0);
    cycles(5);
  endtask

  initial begin
    cycles(3);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_mem_op", {31'h0, dbg_mem_op}, 32'h0);
    chk("rst_wren", {28'h0, dbg_wren}, 32'h0);
    chk("rst_adr", dbg_adr, 32'h0);
    chk("rst_do", dbg_do, 32'h0);
    chk("rst_cpu", {31'h0, cpu_n_reset}, 32'h0);
    reset = 1'b0;
    cycles(2);

    // Aligned word write
    exp_mem(32'h0002_0000, 32'h0001_0537, 4'hF, 1, MEM_CYC);
    tx_q.push_back(8'h06);
    send_byte(8'h57); send_word(32'h0002_0000); send_word(32'h0001_0537);
    drain("write");

    // Read back with transmitter stalled; a byte arriving during RESP is dropped
    tx_ready = 1'b0;
    exp_mem(32'h0002_0000, 32'h0, 4'h0, 0, MEM_CYC);
    tx_q.push_back(8'h37); tx_q.push_back(8'h05); tx_q.push_back(8'h01); tx_q.push_back(8'h00);
    send_byte(8'h52); send_word(32'h0002_0000);
    cycles(6);
    send_byte(8'h47);
    cycles(3);
    chk("stall_tx_valid", {31'h0, tx_valid}, 32'h1);
    chk("drop_in_resp_cpu", {31'h0, cpu_n_reset}, 32'h0);
    tx_ready = 1'b1;
    drain("read");

    // Go, rejected write while running, halt
    tx_q.push_back(8'h06);
    send_byte(8'h47);
    drain("go");
    chk("go_cpu", {31'h0, cpu_n_reset}, 32'h1);
    tx_q.push_back(8'h15);
    send_byte(8'h57); send_word(32'h0002_0000); send_word(32'h1122_3344);
    drain("run_write_nak");
    chk("nak_keeps_cpu", {31'h0, cpu_n_reset}, 32'h1);
    tx_q.push_back(8'h06);
    send_byte(8'h48);
    drain("halt");
    chk("halt_cpu", {31'h0, cpu_n_reset}, 32'h0);

    // Misaligned write/read and unknown command
    tx_q.push_back(8'h15);
    send_byte(8'h57); send_word(32'h0002_0001); send_word(32'hCAFE_F00D);
    drain("misaligned_w");
    tx_q.push_back(8'h15);
    send_byte(8'h52); send_word(32'h0000_0002);
    drain("misaligned_r");
    tx_q.push_back(8'h15);
    send_byte(8'hAA);
    drain("unknown");

    // Inter-byte timeout aborts silently
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    cycles(TO_CYC);
    tx_q.push_back(8'h06);
    send_byte(8'h48);
    drain("timeout");

    // Byte arriving in the expiry cycle keeps the packet alive
    exp_mem(32'h0002_0000, 32'hDEAD_BEEF, 4'hF, 1, MEM_CYC);
    tx_q.push_back(8'h06);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    cycles(TO_CYC - 1);
    send_byte(8'h00); send_word(32'hDEAD_BEEF);
    drain("timeout_edge");

    // Reset during the second MEM cycle of a write
    exp_mem(32'h0000_1000, 32'h0BAD_0BAD, 4'hF, 1, 2);
    send_byte(8'h57); send_word(32'h0000_1000); send_word(32'h0BAD_0BAD);
    cycles(1);
    reset = 1'b1;
    cycles(1);
    chk("rst_mid_mem_op", {31'h0, dbg_mem_op}, 32'h0);
    chk("rst_mid_cpu", {31'h0, cpu_n_reset}, 32'h0);
    chk("rst_mid_tx", {31'h0, tx_valid}, 32'h0);
    cycles(2);
    reset = 1'b0;
    cycles(20);
    drain("rst_mid");

    chk("tx_q_empty", tx_q.size(), 32'h0);
    chk("mem_q_empty", mem_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dbg_loader.md
DBG_LOADER -- requirements
Module: dbg_loader

Interface
REQ-001 Parameter MEM_CYC, default 4: cycles dbg_mem_op is held per memory access (min 1).
REQ-002 Parameter TIMEOUT_CYC, default 100000: idle cycles between packet bytes before abort.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  byte from UART receiver.
REQ-006 rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-007 tx_data  out  8  response byte to UART transmitter.
REQ-008 tx_valid  out  1  response byte valid.
REQ-009 tx_ready  in  1  transmitter accepts byte when tx_valid&&tx_ready.
REQ-010 dbg_mem_op  out  1  debug port owns memory bus.
REQ-011 dbg_adr  out  32  word address, bits [1:0] always 0.
REQ-012 dbg_do  out  32  write data.
REQ-013 dbg_wren  out  4  byte write enables; 4'hF on write, 4'h0 on read.
REQ-014 dbg_di  in  32  read data, valid on the last cycle of a read access.
REQ-015 cpu_n_reset  out  1  CPU reset, active-low; 0 = halted.

Function
REQ-016 Packet commands: 0x57 'W' + addr[4 LE] + data[4 LE]; 0x52 'R' + addr[4 LE]; 0x47 'G'; 0x48 'H'.
REQ-017 States: IDLE, ADDR, DATA, MEM, RESP; IDLE decodes the command byte.
REQ-018 IDLE+'W'/'R' -> ADDR; ADDR after 4th byte -> DATA ('W') or MEM ('R'); DATA after 4th byte -> MEM.
REQ-019 'G' sets cpu_n_reset=1; 'H' sets cpu_n_reset=0; both then RESP with ACK 0x06.
REQ-020 Unknown command byte -> RESP with NAK 0x15.
REQ-021 Complete W/R packet with addr[1:0]!=0, or with cpu_n_reset=1 -> RESP with NAK, no memory access.
REQ-022 MEM: dbg_mem_op=1 for exactly MEM_CYC cycles, dbg_adr/dbg_do/dbg_wren stable throughout; outside MEM dbg_mem_op=0, dbg_wren=0.
REQ-023 W: after MEM, RESP sends ACK. R: dbg_di captured on the last MEM cycle; RESP sends 4 bytes LSB first.
REQ-024 RESP: tx_valid high with tx_data stable until handshake; next byte is presented the cycle after handshake; after last byte -> IDLE.
REQ-025 rx_valid during MEM or RESP: byte dropped, no state change.
REQ-026 Timeout: in ADDR/DATA, TIMEOUT_CYC cycles with no rx_valid -> IDLE silently, no response; counter clears on each rx_valid; rx_valid in the expiry cycle wins.
REQ-027 cpu_n_reset changes only on 'G'/'H' or reset; it is unaffected by aborts and NAKs.

Reset
REQ-028 reset=1: state IDLE, cpu_n_reset=0, dbg_mem_op=0, dbg_wren=0, dbg_adr=0, dbg_do=0, tx_valid=0, tx_data=0, counters=0.
REQ-029 Reset mid-MEM drops dbg_mem_op the next cycle; reset mid-RESP discards the remaining bytes.

Structure
REQ-030 Package dbg_loader_pkg holds the command codes, ACK/NAK codes and the state enum.
REQ-031 Sub-module dbg_resp_tx (4-byte response shift register + tx handshake) is instantiated once.

Verification
REQ-032 After reset send 57 00 00 02 00 37 05 01 00 -> one MEM window: adr 0x20000, do 0x00010537, wren F, 4 cycles; tx 06.
REQ-033 After REQ-032 send 52 00 00 02 00 with dbg_di=0x00010537 -> tx 37 05 01 00 in order; tx_ready held low 10 cycles causes no byte loss.
REQ-034 Send 47 -> cpu_n_reset=1, tx 06; then 57 + addr 0x20000 + any data -> tx 15, dbg_mem_op stays 0; then 48 -> cpu_n_reset=0, tx 06.
REQ-035 Send 57 01 00 02 00 + 4 data bytes -> tx 15, no memory access; send 0xAA -> tx 15.
REQ-036 Send 57 00 00 then idle TIMEOUT_CYC cycles -> no tx, state IDLE; then 48 -> tx 06.
REQ-037 Assert reset during the 2nd MEM cycle of a write -> dbg_mem_op=0 the next cycle, cpu_n_reset=0, no tx.
